// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronizes serial_in, samples each bit at mid-period,
// and presents bytes on a ready/valid slot with framing and overrun pulses.
module uart_receiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);
    localparam int T  = CLOCK_FREQ / BAUD_RATE;
    localparam int S  = T / 2;
    localparam int CW = $clog2(T);
    localparam logic [CW-1:0] CNT_LAST = CW'(T - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(S);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          sync_a;
    logic          serial_sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          sample;
    logic          wrap;
    logic          accept;

    assign sample = (cnt == CNT_MID);
    assign wrap   = (cnt == CNT_LAST);
    assign accept = data_out_valid && data_out_ready;

    // Two-flop synchronizer; resets to the idle line level so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a      <= 1'b1;
            serial_sync <= 1'b1;
        end else begin
            sync_a      <= serial_in;
            serial_sync <= sync_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
            framing_error  <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            if (accept)
                data_out_valid <= 1'b0;
            cnt <= wrap ? '0 : cnt + 1'b1;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!serial_sync)
                        state <= START;
                end
                START: begin
                    // Line back high at mid start bit: a glitch, not a frame.
                    if (sample && serial_sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (wrap) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (sample)
                        shift <= {serial_sync, shift[7:1]};
                    if (wrap) begin
                        if (bit_idx == 3'd7)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    if (sample) begin
                        state <= IDLE;
                        cnt   <= '0;
                        if (!serial_sync) begin
                            framing_error <= 1'b1;
                        end else if (!data_out_valid || data_out_ready) begin
                            data_out       <= shift;
                            data_out_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage: it synchronizes the asynchronous `serial_in` line, detects a start bit, samples 8 data bits LSB-first at mid-bit, checks the stop bit, and presents each byte on a ready/valid output. It is the counterpart of the transmit stage on the same 8N1 link and uses the same `CLOCK_FREQ`/`BAUD_RATE` parameterization, so a transmitter's `serial_out` can be looped directly into this block. Downstream logic (MMIO/FIFO) consumes bytes through `data_out_valid`/`data_out_ready`.

## Interface
- `CLOCK_FREQ`, default 125_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in baud.
- Derived: `T = CLOCK_FREQ / BAUD_RATE` (integer division) clocks per bit.
- Derived: `S = T / 2` mid-bit sample offset.
- Derived: counter width `$clog2(T)`.
- `clk`  input  1  clock; all logic on posedge.
- `reset`  input  1  synchronous, active-high.
- `serial_in`  input  1  asynchronous line; idle high.
- `data_out`  output  8  received byte; stable while `data_out_valid` is high.
- `data_out_valid`  output  1  byte available; held until accepted.
- `data_out_ready`  input  1  consumer accepts when `valid && ready`.
- `framing_error`  output  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  output  1  one-cycle pulse when a byte completes while the previous byte is still unaccepted.

## Operation
- Synchronizer: two flops, both reset to 1, produce `serial_sync`. `serial_sync` is `serial_in` delayed 2 cycles.
- Bit counter `cnt` runs 0..T-1 and wraps to 0. Each wrap advances to the next bit period.
- Sample point: the cycle where `cnt == S` within each bit period.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if `serial_sync == 0`, go to START with `cnt = 0` on the next cycle.
  - START: at the sample point, if `serial_sync == 1`, treat it as a glitch and return to IDLE (no output, no error). Otherwise stay. On the wrap, go to DATA with bit index 0.
  - DATA: at each sample point, shift `serial_sync` into the byte, LSB first. After the wrap of bit 7, go to STOP.
  - STOP, at the sample point, always return to IDLE on the next cycle (allows back-to-back frames):
    - `serial_sync == 1` and output slot empty, or being accepted this cycle: load `data_out` and set `data_out_valid`.
    - `serial_sync == 1` and slot full, not accepted this cycle: drop the new byte, keep the old byte, pulse `overrun`.
    - `serial_sync == 0`: discard the byte and pulse `framing_error`. `data_out`/`data_out_valid` are unchanged.
- Output handshake:
  - `data_out_valid` clears on the cycle after `valid && ready`, unless a new byte loads in that same cycle, in which case valid stays 1 with the new data.
  - `data_out` never changes while valid is high and not accepted.
- Reset (any time, including mid-frame):
  - State IDLE, `cnt` 0, shift register 0, synchronizer flops 1.
  - Outputs: `data_out` 8'h00, `data_out_valid` 0, `framing_error` 0, `overrun` 0.
  - The partial frame is abandoned. A line that is still low after reset is taken as a new start bit.

## Timing
- Let t0 be the first cycle with `serial_sync == 0` in IDLE (t0 is 2 cycles after the falling edge of `serial_in`).
- START is entered at t0+1 with `cnt = 0`.
- Data bit k is sampled at t0+1+(k+1)·T+S.
- Stop bit is sampled at t0+1+9·T+S.
- `data_out_valid` (or a `framing_error`/`overrun` pulse) appears at t0+2+9·T+S.
- Back in IDLE at t0+2+9·T+S. The next start edge can be detected from that cycle on.
- `data_out_ready` has no combinational path to any output; every output is registered.
- Tolerates ±4% baud mismatch between sender and receiver; no resynchronization within a frame.

## Test plan
Bench parameters: `CLOCK_FREQ = 1000`, `BAUD_RATE = 100` (T = 10, S = 5), driving ideal 8N1 frames on `serial_in`.
- Single byte 8'hA5, `data_out_ready` held 0: `data_out_valid` rises exactly at t0+2+9·10+5 with `data_out = 8'hA5`, no error pulses, and valid stays high. Raising ready for one cycle clears valid the next cycle.
- Back-to-back frames 8'h00, 8'hFF, 8'h5A with no idle gap, ready held 1: three valid pulses with matching data in order, no overrun.
- Second byte 8'h3C arrives while 8'h11 is still unaccepted: `overrun` pulses for 1 cycle, `data_out` stays 8'h11. Accept, then send 8'h77: 8'h77 is delivered.
- Stop bit forced low on 8'h42: `framing_error` pulses for 1 cycle, `data_out_valid` stays 0. A following good 8'h24 frame is received correctly.
- `serial_in` glitch low for 3 cycles (shorter than S): no valid, no errors, FSM back in IDLE.
- Reset asserted midway through the data bits of 8'hC3: all outputs 0 the cycle after reset. A fresh 8'h81 frame sent after reset deasserts is received as 8'h81.
